// File: rtl/nibble_serial_subtractor_if.sv
// Handshake and operand/result bundle for the nibble-serial subtractor.
// The master side drives the request; the slave side returns status and results.
interface nibble_serial_subtractor_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             zero;
  logic             ovf;

  modport master (
    output start, in1, in2, bin,
    input  busy, done, diff, bout, zero, ovf
  );

  modport slave (
    input  start, in1, in2, bin,
    output busy, done, diff, bout, zero, ovf
  );
endinterface

// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle subtractor: in1 - in2 - bin, one SLICE-bit slice per clock,
// with the borrow carried between slices in a register.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for start; results held from the last completion
//   RUN   | processing slice cnt_q; final slice publishes results + done
module nibble_serial_subtractor #(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  nibble_serial_subtractor_if.slave  bus
);
  localparam int N   = WIDTH / SLICE;
  localparam int CW  = (N > 1) ? $clog2(N) : 1;
  localparam int MSB = WIDTH - 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic             borrow_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;

  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             zero_q;
  logic             ovf_q;

  int               slice_lsb;
  logic [SLICE-1:0] a_slice;
  logic [SLICE-1:0] b_slice;
  logic [SLICE:0]   slice_sum;
  logic [WIDTH-1:0] acc_next;
  logic             borrow_next;
  logic             last_slice;

  // Subtraction as addition of the inverted subtrahend; carry-in is the
  // inverted borrow, and the new borrow is the inverted carry-out.
  always_comb begin
    slice_lsb   = int'(cnt_q) * SLICE;
    a_slice     = a_q[slice_lsb +: SLICE];
    b_slice     = b_q[slice_lsb +: SLICE];
    slice_sum   = {1'b0, a_slice} + {1'b0, ~b_slice} + {{SLICE{1'b0}}, ~borrow_q};
    acc_next    = acc_q;
    acc_next[slice_lsb +: SLICE] = slice_sum[SLICE-1:0];
    borrow_next = ~slice_sum[SLICE];
    last_slice  = (cnt_q == CW'(N - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_q      <= bus.in1;
            b_q      <= bus.in2;
            borrow_q <= bus.bin;
            cnt_q    <= '0;
            acc_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end
        end
        RUN: begin
          acc_q    <= acc_next;
          borrow_q <= borrow_next;
          cnt_q    <= cnt_q + 1'b1;
          if (last_slice) begin
            // Results publish only here, so partial sums never reach diff.
            diff_q  <= acc_next;
            bout_q  <= borrow_next;
            zero_q  <= (acc_next == '0);
            ovf_q   <= (a_q[MSB] != b_q[MSB]) && (acc_next[MSB] != a_q[MSB]);
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
  assign bus.zero = zero_q;
  assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Self-checking bench for nibble_serial_subtractor: directed cases plus
// randomized operations against an arithmetic reference model.
module tb_nibble_serial_subtractor;
  localparam int W = 32;
  localparam int LAT = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [W-1:0] last_diff;

  nibble_serial_subtractor_if #(.WIDTH(W)) bus ();

  nibble_serial_subtractor #(.WIDTH(W), .SLICE(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: plain wide arithmetic on the operands.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                       output logic [W-1:0] d, output logic bo, output logic z, output logic ov);
    logic [W:0] wide;
    wide = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bi};
    d    = wide[W-1:0];
    bo   = ({1'b0, a} < ({1'b0, b} + {{W{1'b0}}, bi}));
    z    = (d == '0);
    ov   = (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]);
  endtask

  // Launches one operation at the next negedge and follows it to done.
  // poke=1 asserts a second start (0xFF - 0xFF) three cycles in, which must be ignored.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic bi, input bit poke);
    logic [W-1:0] ed;
    logic eb, ez, eo;
    int   n;
    bit   bad_hold;
    bit   bad_overlap;
    model(a, b, bi, ed, eb, ez, eo);
    @(negedge clk);
    bus.start = 1'b1;
    bus.in1   = a;
    bus.in2   = b;
    bus.bin   = bi;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.in1   = $urandom;
    bus.in2   = $urandom;
    bus.bin   = 1'($urandom_range(0, 1));
    check({tag, ".busy_after_start"}, 64'(bus.busy), 64'd1);
    check({tag, ".done_pulse_low"}, 64'(bus.done), 64'd0);
    n = 0;
    bad_hold = 0;
    bad_overlap = 0;
    while (!bus.done && n < 3 * LAT) begin
      if (bus.diff !== last_diff) bad_hold = 1;
      if (bus.busy !== 1'b1) bad_hold = 1;
      @(posedge clk);
      #1;
      n++;
      if (bus.busy && bus.done) bad_overlap = 1;
      if (poke && n == 3) begin
        bus.start = 1'b1;
        bus.in1   = 32'hFF;
        bus.in2   = 32'hFF;
        bus.bin   = 1'b0;
      end else begin
        bus.start = 1'b0;
      end
    end
    check({tag, ".latency"}, 64'(n), 64'(LAT));
    check({tag, ".hold_while_busy"}, 64'(bad_hold), 64'd0);
    check({tag, ".busy_done_overlap"}, 64'(bad_overlap), 64'd0);
    check({tag, ".diff"}, 64'(bus.diff), 64'(ed));
    check({tag, ".bout"}, 64'(bus.bout), 64'(eb));
    check({tag, ".zero"}, 64'(bus.zero), 64'(ez));
    check({tag, ".ovf"}, 64'(bus.ovf), 64'(eo));
    check({tag, ".busy_at_done"}, 64'(bus.busy), 64'd0);
    last_diff = ed;
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    bit saw_done;
    checks    = 0;
    errors    = 0;
    last_diff = '0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.in1   = '0;
    bus.in2   = '0;
    bus.bin   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.busy", 64'(bus.busy), 64'd0);
    check("reset.done", 64'(bus.done), 64'd0);
    check("reset.diff", 64'(bus.diff), 64'd0);
    check("reset.flags", {61'd0, bus.bout, bus.zero, bus.ovf}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    check("tp1.model_diff", 64'(32'h5 - 32'h3), 64'd2);
    run_op("tp1", 32'h0000_0005, 32'h0000_0003, 1'b0, 0);
    check("tp1.diff_const", 64'(bus.diff), 64'h2);
    run_op("tp2", 32'h0000_0000, 32'h0000_0001, 1'b0, 0);
    check("tp2.diff_const", 64'(bus.diff), 64'hFFFF_FFFF);
    run_op("tp3a", 32'h8000_0000, 32'h0000_0001, 1'b0, 0);
    check("tp3a.ovf_const", 64'(bus.ovf), 64'd1);
    run_op("tp3b", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
    check("tp3b.diff_const", 64'(bus.diff), 64'h8000_0000);
    run_op("tp4", 32'h1234_5678, 32'h1234_5677, 1'b1, 0);
    check("tp4.zero_const", 64'(bus.zero), 64'd1);

    // Ignored start mid-operation, then back-to-back acceptance in the done cycle.
    run_op("tp5a", 32'h10, 32'h01, 1'b0, 1);
    check("tp5a.diff_const", 64'(bus.diff), 64'hF);
    run_op("tp5c", 32'h20, 32'h30, 1'b0, 0);
    check("tp5c.diff_const", 64'(bus.diff), 64'hFFFF_FFF0);

    // Asynchronous reset mid-operation.
    @(negedge clk);
    bus.start = 1'b1;
    bus.in1   = 32'h1234;
    bus.in2   = 32'h0004;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("tp6.busy_async", 64'(bus.busy), 64'd0);
    check("tp6.done_async", 64'(bus.done), 64'd0);
    check("tp6.diff_async", 64'(bus.diff), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    last_diff = '0;
    saw_done = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) saw_done = 1;
    end
    check("tp6.no_done_after_abort", 64'(saw_done), 64'd0);
    run_op("tp6.fresh", 32'h0000_0100, 32'h0000_0001, 1'b0, 0);

    for (int i = 0; i < 30; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
      run_op($sformatf("rand%0d", i), ra, rb, 1'($urandom_range(0, 1)), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
